// File: rtl/crotchet_sequencer_if.sv
// Control and status bundle between the crotchet sequencer and its host.
// The master drives the controls and frame ticks; the slave (the sequencer) drives the status.
interface crotchet_sequencer_if;
    logic       frame_tick;
    logic       start;
    logic       stop;
    logic       pause;
    logic       loop_en;
    logic [6:0] frame_len;
    logic [6:0] crotchet;
    logic [3:0] phrase;
    logic [2:0] beat;
    logic       crotchet_pulse;
    logic       playing;
    logic       done;

    modport master (
        output frame_tick, start, stop, pause, loop_en, frame_len,
        input  crotchet, phrase, beat, crotchet_pulse, playing, done
    );

    modport slave (
        input  frame_tick, start, stop, pause, loop_en, frame_len,
        output crotchet, phrase, beat, crotchet_pulse, playing, done
    );
endinterface

// File: rtl/crotchet_sequencer.sv
// Frame-locked crotchet scheduler: counts frame ticks and steps a {phrase, beat} index
// with start/stop/pause/loop control and a strobe on every index change.

// Elaboration-time legality checks on the sequencer geometry.
module crotchet_sequencer_param_chk #(
    parameter int NUM_PHRASES          = 13,
    parameter int CROTCHETS_PER_PHRASE = 8
);
    if ((NUM_PHRASES * CROTCHETS_PER_PHRASE) > 128) begin : g_len_err
        $error("crotchet_sequencer: NUM_PHRASES*CROTCHETS_PER_PHRASE exceeds 128");
    end
    if ((CROTCHETS_PER_PHRASE < 2) ||
        ((CROTCHETS_PER_PHRASE & (CROTCHETS_PER_PHRASE - 1)) != 0)) begin : g_pow2_err
        $error("crotchet_sequencer: CROTCHETS_PER_PHRASE must be a power of two");
    end
endmodule

module crotchet_sequencer #(
    parameter int NUM_PHRASES          = 13,
    parameter int CROTCHETS_PER_PHRASE = 8,
    parameter int FRAMES_PER_CROTCHET  = 52
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crotchet_sequencer_if.slave   bus
);
    localparam int         BEAT_W    = $clog2(CROTCHETS_PER_PHRASE);
    localparam logic [6:0] LAST_IDX  = 7'(NUM_PHRASES * CROTCHETS_PER_PHRASE - 1);
    localparam logic [6:0] DEF_LEN   = 7'(FRAMES_PER_CROTCHET);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    crotchet_sequencer_param_chk #(
        .NUM_PHRASES          (NUM_PHRASES),
        .CROTCHETS_PER_PHRASE (CROTCHETS_PER_PHRASE)
    ) u_param_chk ();

    state_t     state_r, state_s;
    logic [6:0] cnt_r, cnt_s;
    logic [6:0] len_r, len_s;
    logic [6:0] crot_r, crot_s;
    logic       pulse_r, pulse_s;
    logic       playing_r, done_r;

    // State, counters and status flags; flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 7'd0;
            len_r     <= DEF_LEN;
            crot_r    <= 7'd0;
            pulse_r   <= 1'b0;
            playing_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            len_r     <= len_s;
            crot_r    <= crot_s;
            pulse_r   <= pulse_s;
            playing_r <= (state_s == ST_PLAY) || (state_s == ST_PAUSE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    // Next-state logic: stop beats start, start beats ticks and pause.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        len_s   = len_r;
        crot_s  = crot_r;
        pulse_s = 1'b0;
        if (bus.stop) begin
            state_s = ST_IDLE;
            cnt_s   = 7'd0;
            crot_s  = 7'd0;
        end else if (bus.start) begin
            len_s   = (bus.frame_len == 7'd0) ? DEF_LEN : bus.frame_len;
            cnt_s   = 7'd0;
            crot_s  = 7'd0;
            pulse_s = 1'b1;
            state_s = bus.pause ? ST_PAUSE : ST_PLAY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_PLAY: begin
                    if (bus.pause) begin
                        state_s = ST_PAUSE;
                    end else if (bus.frame_tick) begin
                        if (cnt_r == (len_r - 7'd1)) begin
                            cnt_s = 7'd0;
                            // Power-of-two beats: a plain increment carries beat into phrase.
                            if (crot_r == LAST_IDX) begin
                                if (bus.loop_en) begin
                                    crot_s  = 7'd0;
                                    pulse_s = 1'b1;
                                end else begin
                                    state_s = ST_DONE;
                                end
                            end else begin
                                crot_s  = crot_r + 7'd1;
                                pulse_s = 1'b1;
                            end
                        end else begin
                            cnt_s = cnt_r + 7'd1;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) begin
                        state_s = ST_PLAY;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 7'd0;
                    crot_s  = 7'd0;
                end
            endcase
        end
    end

    assign bus.crotchet       = crot_r;
    assign bus.beat           = crot_r[BEAT_W-1:0];
    assign bus.phrase         = crot_r[6:BEAT_W];
    assign bus.crotchet_pulse = pulse_r;
    assign bus.playing        = playing_r;
    assign bus.done           = done_r;
endmodule

// File: tb/tb_crotchet_sequencer.sv
// Directed bench for crotchet_sequencer: a one-cycle-per-row vector table plus
// hand-written long sequences for wrap, loop, pause and asynchronous reset.
module tb_crotchet_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    crotchet_sequencer_if bus ();

    crotchet_sequencer #(
        .NUM_PHRASES          (13),
        .CROTCHETS_PER_PHRASE (8),
        .FRAMES_PER_CROTCHET  (52)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st, sp, pa, le, tk;
        logic [6:0] fl;
        logic [6:0] e_crot;
        logic       e_pls, e_ply, e_dn;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(logic st, logic sp, logic pa, logic le, logic tk,
                                logic [6:0] fl, logic [6:0] ec, logic ep, logic ey, logic ed);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.le = le; v.tk = tk; v.fl = fl;
        v.e_crot = ec; v.e_pls = ep; v.e_ply = ey; v.e_dn = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int ec, input int ep, input int ey, input int ed);
        chk({name, ".crotchet"}, int'(bus.crotchet), ec);
        chk({name, ".phrase"},   int'(bus.phrase),   ec / 8);
        chk({name, ".beat"},     int'(bus.beat),     ec % 8);
        chk({name, ".pulse"},    int'(bus.crotchet_pulse), ep);
        chk({name, ".playing"},  int'(bus.playing),  ey);
        chk({name, ".done"},     int'(bus.done),     ed);
    endtask

    // One clock: inputs applied at the falling edge, outputs observed 1 after the rising edge.
    task automatic step(input logic st, input logic sp, input logic pa, input logic le,
                        input logic tk, input logic [6:0] fl);
        @(negedge clk);
        bus.start = st; bus.stop = sp; bus.pause = pa; bus.loop_en = le;
        bus.frame_tick = tk; bus.frame_len = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.loop_en = 1'b0;
        bus.frame_tick = 1'b0; bus.frame_len = 7'd0;

        //          st    sp    pa    le    tk    fl     crot  pls   ply   dn
        vt[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 7'd0, 1'b1, 1'b1, 1'b0);
        vt[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 7'd0, 1'b0, 1'b1, 1'b0);
        vt[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 7'd0, 1'b0, 1'b1, 1'b0);
        vt[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 7'd1, 1'b1, 1'b1, 1'b0);
        vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 7'd1, 1'b0, 1'b1, 1'b0);
        vt[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 7'd2, 1'b1, 1'b1, 1'b0);
        vt[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 7'd2, 1'b0, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd2, 7'd2, 1'b0, 1'b1, 1'b0);
        vt[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b0, 1'b1, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 7'd2, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 7'd3, 1'b1, 1'b1, 1'b0);
        vt[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 7'd0, 1'b1, 1'b1, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 7'd1, 1'b1, 1'b1, 1'b0);
        vt[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 7'd0, 1'b0, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 7'd0, 1'b0, 1'b0, 1'b0);
        vt[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 7'd0, 1'b0, 1'b0, 1'b0);
        vt[16] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd3, 7'd0, 1'b1, 1'b1, 1'b0);
        vt[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd3, 7'd0, 1'b0, 1'b1, 1'b0);
        vt[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd3, 7'd0, 1'b0, 1'b1, 1'b0);
        vt[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 7'd0, 1'b0, 1'b1, 1'b0);
        vt[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 7'd0, 1'b0, 1'b1, 1'b0);
        vt[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 7'd1, 1'b1, 1'b1, 1'b0);
        vt[22] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 7'd0, 1'b0, 1'b0, 1'b0);

        // Reset state.
        #12;
        chk_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Table of single-cycle vectors.
        for (int i = 0; i < 23; i++) begin
            step(vt[i].st, vt[i].sp, vt[i].pa, vt[i].le, vt[i].tk, vt[i].fl);
            chk_all($sformatf("vec%0d", i), int'(vt[i].e_crot), int'(vt[i].e_pls),
                    int'(vt[i].e_ply), int'(vt[i].e_dn));
        end

        // Length 4, ticks every 10 clocks: four pulses in all.
        do_reset();
        pulses = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd4);
        chk_all("t1.start", 0, 1, 1, 0);
        pulses += int'(bus.crotchet_pulse);
        for (int k = 1; k <= 12; k++) begin
            for (int j = 0; j < 9; j++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
                pulses += int'(bus.crotchet_pulse);
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
            pulses += int'(bus.crotchet_pulse);
            chk_all($sformatf("t1.tick%0d", k), k / 4, (k % 4 == 0) ? 1 : 0, 1, 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        pulses += int'(bus.crotchet_pulse);
        chk("t1.pulse_count", pulses, 4);

        // Length 1 without loop: run to the end and stick in DONE.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1);
        for (int k = 1; k <= 110; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
            if (k <= 103) chk_all($sformatf("t2.tick%0d", k), k, 1, 1, 0);
            else          chk_all($sformatf("t2.tick%0d", k), 103, 0, 0, 1);
        end
        chk("t2.phrase_end", int'(bus.phrase), 12);
        chk("t2.beat_end", int'(bus.beat), 7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        chk_all("t2.hold", 103, 0, 0, 1);

        // Same with loop enabled: wrap back to 0 with a pulse; start from DONE works.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd1);
        chk_all("t3.start", 0, 1, 1, 0);
        for (int k = 1; k <= 105; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0);
            if (k == 103)      chk_all("t3.tick103", 103, 1, 1, 0);
            else if (k == 104) chk_all("t3.tick104", 0, 1, 1, 0);
            else if (k == 105) chk_all("t3.tick105", 1, 1, 1, 0);
        end

        // Pause mid-crotchet: ticks ignored, count resumes from where it stopped.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0);
            chk_all($sformatf("t4.paused%0d", k), 0, 0, 1, 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        chk_all("t4.post1", 0, 0, 1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        chk_all("t4.post2", 1, 1, 1, 0);

        // Asynchronous reset between clock edges, mid-crotchet.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t6.async", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
            chk_all($sformatf("t6.idle%0d", k), 0, 0, 0, 0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        chk_all("t6.start", 0, 1, 1, 0);
        for (int k = 1; k <= 52; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
            if (k == 51)      chk_all("t6.tick51", 0, 0, 1, 0);
            else if (k == 52) chk_all("t6.tick52", 1, 1, 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crotchet_sequencer.md
Name: crotchet_sequencer

Overview:
Frame-locked scheduler that produces the `crotchet` index consumed by the display renderer and the music voices. It counts `vsync_pulse` frame ticks from the VGA timing block and advances through NUM_PHRASES phrases of CROTCHETS_PER_PHRASE crotchets. It supports start, pause, stop and looping. It emits a one-cycle strobe on every crotchet change, so downstream logic can reload per-crotchet state.

Parameters:
- NUM_PHRASES, 13, number of phrases in the sequence.
- CROTCHETS_PER_PHRASE, 8, crotchets per phrase; must be a power of two.
- FRAMES_PER_CROTCHET, 52, default frame count per crotchet, used when `frame_len` is 0.
- Legality: NUM_PHRASES*CROTCHETS_PER_PHRASE <= 128 (elaboration-time assertion).

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst_n  in  1  reset; asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse per frame (VGA `vsync_pulse`).
- start  in  1  pulse; begin/restart the sequence from crotchet 0.
- stop  in  1  pulse; abort and return to idle.
- pause  in  1  level; freezes frame counting while high.
- loop_en  in  1  level; wrap to crotchet 0 after the last crotchet instead of finishing.
- frame_len  in  7  frames per crotchet, sampled on an accepted `start`; 0 selects FRAMES_PER_CROTCHET.
- crotchet  out  7  current crotchet index, {phrase, beat}.
- phrase  out  4  current phrase index.
- beat  out  3  crotchet within phrase (log2(CROTCHETS_PER_PHRASE) bits).
- crotchet_pulse  out  1  one-cycle strobe when `crotchet` takes a new value, including entry to crotchet 0.
- playing  out  1  high in PLAY or PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - `crotchet`, `phrase`, `beat` = 0.
  - Frame counter = 0; latched length = FRAMES_PER_CROTCHET.
  - `crotchet_pulse`, `playing`, `done` = 0.
- States and transitions:
  - IDLE: outputs held at 0. `start` -> PLAY.
  - PLAY: counts frames. `pause` high -> PAUSE. Last crotchet complete and `loop_en`=0 -> DONE.
  - PAUSE: `frame_tick` ignored; frame counter and crotchet held. `pause` low -> PLAY, counter resumes from the held value.
  - DONE: `crotchet` held at the last index (NUM_PHRASES*CROTCHETS_PER_PHRASE-1). `start` -> PLAY.
- Priority: `stop` > `start` > `frame_tick`/`pause`.
  - `stop` from any state -> IDLE next cycle: crotchet 0, counter 0, no pulse.
  - `start` in any state, with no `stop` that cycle:
    - Latch `frame_len` (0 -> default); counter 0; crotchet 0.
    - Assert `crotchet_pulse` the next cycle.
    - Go to PLAY, or to PAUSE if `pause` is high.
    - A `frame_tick` in the same cycle is discarded.
- Frame counting in PLAY:
  - On `frame_tick`, if counter == len-1: counter <= 0 and advance the crotchet; otherwise counter++.
  - With len=1, every tick advances.
- Crotchet advance:
  - `beat`++. When `beat` wraps to 0, `phrase`++.
  - After phrase NUM_PHRASES-1, beat max:
    - `loop_en`=1: go to crotchet 0 with a pulse.
    - `loop_en`=0: enter DONE with no pulse; `crotchet` stays at the last index.
  - `loop_en` is sampled at the wrap point.
- Registered outputs and latency:
  - `crotchet`, `phrase`, `beat` update one clk after the qualifying `frame_tick`.
  - `crotchet_pulse` is high in that same cycle only.
  - `crotchet` always equals {phrase, beat}.
- `frame_len` changes outside an accepted `start` have no effect.
- Counter is 7 bits and never exceeds len-1.

Test Plan:
1. Reset, then `start` with `frame_len`=4 and 12 `frame_tick`s spaced 10 clk apart:
   - `crotchet_pulse` 1 clk after `start` with crotchet=0.
   - Crotchet 1 appears 1 clk after tick 4; crotchet 2 after tick 8; crotchet 3 after tick 12.
   - Exactly 4 pulses in total.
2. `frame_len`=1, `loop_en`=0, 110 ticks:
   - Crotchet reaches 103 (phrase 12, beat 7).
   - Tick 104 -> `done`=1, crotchet stays 103, no pulse; `playing`=0.
   - Further ticks cause no change.
3. Same as 2 with `loop_en`=1:
   - Tick 104 -> crotchet=0 with a pulse; `playing` stays 1.
   - Tick 105 -> crotchet=1.
4. `frame_len`=4, 2 ticks, raise `pause`, apply 5 ticks, lower `pause`:
   - No change while paused.
   - Crotchet 1 appears after the 2nd post-pause tick.
5. During PLAY, assert `start` and `stop` in the same cycle:
   - IDLE, crotchet=0, no pulse.
   - Separately, `start` coincident with `frame_tick`: tick ignored, crotchet 0 pulse only.
6. Assert `rst_n` low asynchronously mid-crotchet, with no clock edge:
   - All outputs 0 immediately.
   - After release, state stays IDLE until `start`.
   - `frame_len`=0 then yields 52-frame crotchets.
